// File: rtl/recog_pkg.sv
// recog_pkg: shared FSM encoding, recognizer output codes and counter width helper
package recog_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;
  localparam logic [1:0] Z_HIT11 = 2'b11;
  localparam logic [1:0] Z_HIT10 = 2'b10;
  function automatic int cnt_w(input int wlen);
    return $clog2(wlen + 1);
  endfunction
endpackage

// File: rtl/recog_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] c;
  // Walk candidates farthest-first so the nearest requester after last wins.
  always_comb begin
    win = '0;
    idx = '0;
    c = '0;
    for (int i = NREQ; i >= 1; i--) begin
      c = IW'((int'(last) + i) % NREQ);
      if (req[c]) begin
        idx = c;
        win = NREQ'(1) << c;
      end
    end
  end
endmodule

// File: rtl/recog_scheduler.sv
// recog_scheduler: round-robin sharing of one serial sequence recognizer among NREQ requesters.
// RECOG_LSB_FIRST_EN selects LSB-first shifting; the default build shifts MSB-first.
module recog_scheduler import recog_pkg::*; #(
  parameter int NREQ = 2,
  parameter int WLEN = 8
) (
  input  logic                      Ck,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WLEN-1:0]      word,
  output logic [NREQ-1:0]           grant,
  output logic                      done,
  output logic [cnt_w(WLEN)-1:0]    cnt11,
  output logic [cnt_w(WLEN)-1:0]    cnt10,
  output logic                      rec_clr,
  output logic                      rec_x,
  input  logic [1:0]                rec_z
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_w(WLEN);
  localparam int BW = $clog2(WLEN);
  state_t st, nxt;
  logic [WLEN-1:0] sh, sh_nx;
  logic [BW-1:0] bcnt;
  logic [IW-1:0] last, widx, idx;
  logic [NREQ-1:0] win;
  logic nbit, last_bit, samp;

  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req), .last(last), .win(win), .idx(idx));

`ifdef RECOG_LSB_FIRST_EN
  assign nbit = sh[0];
  assign sh_nx = sh >> 1;
`else
  assign nbit = sh[WLEN-1];
  assign sh_nx = sh << 1;
`endif
  assign last_bit = bcnt == BW'(WLEN - 1);
  // The recognizer output lags its input by one cycle, so the first SHIFT cycle has nothing to sample.
  assign samp = (st == SHIFT && bcnt != '0) || st == DRAIN;

  always_ff @(posedge Ck or posedge reset)
    if (reset) st <= IDLE;
    else st <= nxt;

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = |req ? CLEAR : IDLE;
      CLEAR:   nxt = SHIFT;
      SHIFT:   nxt = last_bit ? DRAIN : SHIFT;
      DRAIN:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Ck or posedge reset) begin
    if (reset) begin
      grant <= '0;
      done <= 1'b0;
      cnt11 <= '0;
      cnt10 <= '0;
      rec_clr <= 1'b1;
      rec_x <= 1'b0;
      sh <= '0;
      bcnt <= '0;
      widx <= '0;
      last <= IW'(NREQ - 1);
    end else begin
      rec_clr <= st == IDLE && |req;
      done <= st == DRAIN;
      if (samp && rec_z == Z_HIT11 && cnt11 != CW'(WLEN)) cnt11 <= cnt11 + 1'b1;
      if (samp && rec_z == Z_HIT10 && cnt10 != CW'(WLEN)) cnt10 <= cnt10 + 1'b1;
      case (st)
        IDLE: if (|req) begin
          grant <= win;
          widx <= idx;
          sh <= word[idx*WLEN +: WLEN];
          cnt11 <= '0;
          cnt10 <= '0;
        end
        CLEAR: begin
          rec_x <= nbit;
          sh <= sh_nx;
          bcnt <= '0;
        end
        SHIFT: begin
          rec_x <= last_bit ? 1'b0 : nbit;
          sh <= sh_nx;
          bcnt <= bcnt + 1'b1;
        end
        DONE: begin
          grant <= '0;
          last <= widx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_recog_scheduler.sv
// tb_recog_scheduler: scoreboard bench; attaches a delayed Mealy recognizer (..11 -> 2'b11, ..101 -> 2'b10).
`timescale 1ns/1ps
module tb_recog_scheduler;
  localparam int NREQ = 2;
  localparam int WLEN = 8;
  localparam int CW = $clog2(WLEN + 1);
  typedef struct {int idx; int c11; int c10;} exp_t;

  logic Ck = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*WLEN-1:0] word = '0;
  logic [NREQ-1:0] grant;
  logic done, rec_clr, rec_x;
  logic [CW-1:0] cnt11, cnt10;
  logic [1:0] rec_z = 2'b00;
  logic [1:0] rs = 2'd0;
  int tests = 0, fails = 0, cyc = 0;
  exp_t sb[$];
  logic [NREQ-1:0] req_s = '0, busy = '0, seen_g = '0, gprev = '0;
  logic donep = 1'b0;
  int mlast = NREQ - 1, owner = -1, g_cyc = 0, last_done = -1, reissue = 0;
  bit rand_on = 0, b2b = 0;

  recog_scheduler #(.NREQ(NREQ), .WLEN(WLEN)) dut (
    .Ck(Ck), .reset(reset), .req(req), .word(word), .grant(grant), .done(done),
    .cnt11(cnt11), .cnt10(cnt10), .rec_clr(rec_clr), .rec_x(rec_x), .rec_z(rec_z)
  );

  always #5 Ck = ~Ck;

  always @(posedge Ck) begin
    cyc <= cyc + 1;
    req_s <= req;
  end

  // Recognizer: rs 0 = nothing, 1 = last bit 1, 2 = last bits 10; output registered.
  always @(posedge Ck)
    if (rec_clr) begin
      rs <= 2'd0;
      rec_z <= 2'b00;
    end else begin
      rec_z <= (rec_x && rs == 2'd1) ? 2'b11 : (rec_x && rs == 2'd2) ? 2'b10 : 2'b00;
      rs <= rec_x ? 2'd1 : (rs == 2'd1 ? 2'd2 : 2'd0);
    end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int i, input logic [WLEN-1:0] w);
    int b[WLEN];
    exp_t e;
    e.idx = i;
    e.c11 = 0;
    e.c10 = 0;
    for (int k = 0; k < WLEN; k++)
`ifdef RECOG_LSB_FIRST_EN
      b[k] = int'(w[k]);
`else
      b[k] = int'(w[WLEN-1-k]);
`endif
    for (int k = 1; k < WLEN; k++) begin
      if (b[k-1] == 1 && b[k] == 1) e.c11++;
      if (k >= 2 && b[k-2] == 1 && b[k-1] == 0 && b[k] == 1) e.c10++;
    end
    return e;
  endfunction

  function automatic int rr(input logic [NREQ-1:0] r, input int lst);
    for (int i = 1; i <= NREQ; i++)
      if (r[(lst + i) % NREQ]) return (lst + i) % NREQ;
    return -1;
  endfunction

  task automatic push(input int i);
    sb.push_back(model(i, word[i*WLEN +: WLEN]));
  endtask

  task automatic issue(input int i, input logic [WLEN-1:0] w);
    word[i*WLEN +: WLEN] = w;
    req[i] = 1'b1;
    busy[i] = 1'b1;
    push(i);
  endtask

  // Requester agents: react to done/grant, optionally reissue, alter word or drop req after grant.
  task automatic tick();
    @(negedge Ck);
    for (int i = 0; i < NREQ; i++) begin
      if (done && grant[i]) begin
        busy[i] = 1'b0;
        seen_g[i] = 1'b0;
        if (req[i]) begin
          if (reissue > 0) begin
            reissue--;
            busy[i] = 1'b1;
            push(i);
          end else if (rand_on && $urandom_range(1, 0) == 1) begin
            word[i*WLEN +: WLEN] = WLEN'($urandom);
            busy[i] = 1'b1;
            push(i);
          end else req[i] = 1'b0;
        end
      end else if (grant[i] && !seen_g[i]) begin
        seen_g[i] = 1'b1;
        if (rand_on && $urandom_range(3, 0) == 0) word[i*WLEN +: WLEN] = WLEN'($urandom);
        if (rand_on && $urandom_range(7, 0) == 0) req[i] = 1'b0;
      end else if (rand_on && !busy[i] && $urandom_range(3, 0) == 0) issue(i, WLEN'($urandom));
    end
  endtask

  task automatic wait_empty(input int bound, input string name);
    int n = 0;
    while ((sb.size() != 0 || busy != '0) && n < bound) begin
      tick();
      n++;
    end
    chk(name, sb.size() + int'(busy != '0), 0);
  endtask

  task automatic wait_grant(input int i, input int bound);
    int n = 0;
    while (!grant[i] && n < bound) begin
      tick();
      n++;
    end
    chk("grant_wait", int'(grant[i]), 1);
  endtask

  task automatic check_done();
    int k = -1;
    chk("done_pulse", int'(donep), 0);
    chk("done_owner", int'(grant), owner < 0 ? 0 : 1 << owner);
    chk("done_latency", cyc - g_cyc, WLEN + 2);
    if (b2b && last_done >= 0) chk("done_period", cyc - last_done, WLEN + 4);
    last_done = cyc;
    foreach (sb[j]) if (k < 0 && sb[j].idx == owner) k = j;
    chk("sb_entry_found", int'(k >= 0), 1);
    if (k >= 0) begin
      chk("cnt11", int'(cnt11), sb[k].c11);
      chk("cnt10", int'(cnt10), sb[k].c10);
      sb.delete(k);
    end
    if (owner >= 0) mlast = owner;
    owner = -1;
  endtask

  always @(negedge Ck or posedge reset) begin
    if (reset) begin
      mlast = NREQ - 1;
      owner = -1;
      gprev = '0;
      donep = 1'b0;
    end else begin
      if (grant != '0 && gprev == '0) begin
        owner = rr(req_s, mlast);
        chk("grant_rr", int'(grant), owner < 0 ? 0 : 1 << owner);
        g_cyc = cyc;
      end
      if (done) check_done();
      gprev = grant;
      donep = done;
    end
  end

  initial begin
    repeat (3) @(negedge Ck);
    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt11", int'(cnt11), 0);
    chk("rst_cnt10", int'(cnt10), 0);
    chk("rst_rec_clr", int'(rec_clr), 1);
    chk("rst_rec_x", int'(rec_x), 0);
    reset = 1'b0;
    issue(0, 8'b1100_0000);
    wait_empty(40, "d_w0");
    issue(1, 8'b0101_0000);
    wait_empty(40, "d_w1");
    issue(0, 8'b0000_0011);
    wait_empty(40, "d_w0_low");
    issue(1, 8'b1011_0110);
    wait_grant(1, 20);
    tick();
    word[WLEN +: WLEN] = 8'b1111_1111;
    wait_empty(40, "d_word_change");
    b2b = 1;
    last_done = -1;
    reissue = 4;
    issue(0, WLEN'($urandom));
    issue(1, WLEN'($urandom));
    wait_empty(150, "d_back_to_back");
    b2b = 0;
    issue(0, 8'b1111_1111);
    wait_grant(0, 20);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("rstmid_grant", int'(grant), 0);
    chk("rstmid_done", int'(done), 0);
    chk("rstmid_cnt11", int'(cnt11), 0);
    chk("rstmid_cnt10", int'(cnt10), 0);
    chk("rstmid_rec_clr", int'(rec_clr), 1);
    @(negedge Ck);
    reset = 1'b0;
    seen_g = '0;
    wait_empty(40, "d_reset_reserve");
    rand_on = 1;
    repeat (600) tick();
    rand_on = 0;
    wait_empty(200, "r_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
